// File: rtl/cmp3_pkg.sv
// Shared types and constants for the 3-bit comparator sweep checker.
package cmp3_pkg;
    localparam int VEC_COUNT = 64;
    localparam int IDX_W     = 6;
    localparam int ERR_W     = 7;
    localparam int CNT_W     = 4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_COUNT - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = ERR_W'(VEC_COUNT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_e;
endpackage

// File: rtl/cmp3_sweep_checker_if.sv
// Bundle of control, stimulus and result signals between the checker and its environment.
import cmp3_pkg::*;

interface cmp3_sweep_checker_if;
    logic             start_i;
    logic [2:0]       a_o;
    logic [2:0]       b_o;
    logic             dut_gt_i;
    logic             dut_eq_i;
    logic             dut_lt_i;
    logic             busy_o;
    logic             done_o;
    logic             pass_o;
    logic [ERR_W-1:0] err_count_o;
    logic [IDX_W-1:0] first_fail_idx_o;
    logic             first_fail_valid_o;

    modport slave (
        input  start_i, dut_gt_i, dut_eq_i, dut_lt_i,
        output a_o, b_o, busy_o, done_o, pass_o, err_count_o,
               first_fail_idx_o, first_fail_valid_o
    );

    modport master (
        output start_i, dut_gt_i, dut_eq_i, dut_lt_i,
        input  a_o, b_o, busy_o, done_o, pass_o, err_count_o,
               first_fail_idx_o, first_fail_valid_o
    );
endinterface

// File: rtl/cmp3_golden.sv
// Reference 3-bit magnitude comparator; its outputs are always one-hot.
module cmp3_golden (
    input  logic [2:0] a_i,
    input  logic [2:0] b_i,
    output logic       exp_gt_o,
    output logic       exp_eq_o,
    output logic       exp_lt_o
);
    assign exp_gt_o = (a_i >  b_i);
    assign exp_eq_o = (a_i == b_i);
    assign exp_lt_o = (a_i <  b_i);
endmodule

// File: rtl/cmp3_sweep_checker.sv
// Walks all 64 {a,b} operand pairs through an external comparator, holding each
// for SETTLE_CYCLES before checking the response against the golden model.
import cmp3_pkg::*;

module cmp3_sweep_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    cmp3_sweep_checker_if.slave  bus
);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [IDX_W-1:0] ffi_q, ffi_d;
    logic             ffv_q, ffv_d;

    logic exp_gt, exp_eq, exp_lt;
    logic mismatch;

    cmp3_golden u_golden (
        .a_i      (idx_q[5:3]),
        .b_i      (idx_q[2:0]),
        .exp_gt_o (exp_gt),
        .exp_eq_o (exp_eq),
        .exp_lt_o (exp_lt)
    );

    // Golden is one-hot, so any non-one-hot response is caught by the inequality.
    assign mismatch = {bus.dut_gt_i, bus.dut_eq_i, bus.dut_lt_i} != {exp_gt, exp_eq, exp_lt};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            ffi_q   <= '0;
            ffv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ffi_q   <= ffi_d;
            ffv_q   <= ffv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ffi_d   = ffi_q;
        ffv_d   = ffv_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start_i) begin
                    state_d = SETTLE;
                    idx_d   = '0;
                    err_d   = '0;
                    ffv_d   = 1'b0;
                    cnt_d   = SETTLE_LD;
                end
            end
            SETTLE: begin
                if (cnt_q <= CNT_W'(1)) state_d = CHECK;
                else                    cnt_d   = cnt_q - CNT_W'(1);
            end
            CHECK: begin
                if (mismatch) begin
                    if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
                    if (!ffv_q) begin
                        ffi_d = idx_q;
                        ffv_d = 1'b1;
                    end
                end
                // Stop on the last vector rather than wrapping, so a/b stay at 7/7 in DONE.
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    cnt_d   = SETTLE_LD;
                    state_d = SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.a_o                = idx_q[5:3];
    assign bus.b_o                = idx_q[2:0];
    assign bus.busy_o             = (state_q == SETTLE) || (state_q == CHECK);
    assign bus.done_o             = (state_q == DONE);
    assign bus.pass_o             = (state_q == DONE) && (err_q == '0);
    assign bus.err_count_o        = err_q;
    assign bus.first_fail_idx_o   = ffi_q;
    assign bus.first_fail_valid_o = ffv_q;
endmodule

// File: doc/cmp3_sweep_checker.md
CMP3_SWEEP_CHECKER -- requirements
Module: cmp3_sweep_checker

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: cycles each vector is held before sampling; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  one-cycle pulse that begins an exhaustive sweep.
REQ-005 a  output  3  comparator operand A driven to the DUT (first/second/third input, MSB first).
REQ-006 b  output  3  comparator operand B driven to the DUT (fourth/fifth/sixth input, MSB first).
REQ-007 dut_gt  input  1  DUT output, high when A>B.
REQ-008 dut_eq  input  1  DUT output, high when A==B.
REQ-009 dut_lt  input  1  DUT output, high when A<B.
REQ-010 busy  output  1  high while a sweep is in progress.
REQ-011 done  output  1  high after a sweep completes; held until the next accepted start.
REQ-012 pass  output  1  done and err_count==0.
REQ-013 err_count  output  7  number of mismatching vectors in the last sweep, 0..64.
REQ-014 first_fail_idx  output  6  index {a,b} of the first mismatching vector.
REQ-015 first_fail_valid  output  1  first_fail_idx holds a captured value.

Function
REQ-016 The vector index idx SHALL be a 6-bit register; a=idx[5:3] and b=idx[2:0], both registered, with no combinational path from the inputs.
REQ-017 FSM states SHALL be IDLE, SETTLE, CHECK and DONE.
REQ-018 In IDLE or DONE, start SHALL clear idx, err_count, first_fail_valid and done, load the settle counter, and enter SETTLE on the next edge.
REQ-019 SETTLE SHALL last exactly SETTLE_CYCLES cycles and then enter CHECK.
REQ-020 CHECK SHALL last one cycle, comparing {dut_gt,dut_eq,dut_lt} against the golden result for the current idx.
REQ-021 A mismatch SHALL include any non-one-hot DUT output pattern.
REQ-022 On a mismatch, err_count SHALL increment.
REQ-023 On the first mismatch of a sweep, first_fail_idx SHALL be set to idx and first_fail_valid to 1.
REQ-024 After CHECK with idx<63, idx SHALL increment and the FSM SHALL return to SETTLE.
REQ-025 After CHECK with idx==63, the FSM SHALL enter DONE with no wrap to 0.
REQ-026 A full sweep SHALL take 64*(SETTLE_CYCLES+1) cycles, measured from the first SETTLE cycle to done asserting.
REQ-027 start SHALL be ignored while busy (SETTLE or CHECK).
REQ-028 busy SHALL be high exactly in SETTLE and CHECK.
REQ-029 done SHALL be high exactly in DONE.
REQ-030 err_count SHALL never wrap; its maximum is 64.

Reset
REQ-031 Reset SHALL force IDLE.
REQ-032 Reset SHALL clear a, b, idx, the settle counter, err_count, first_fail_idx, first_fail_valid, busy, done and pass to 0.
REQ-033 Reset mid-sweep SHALL abort the sweep with no partial results retained.
REQ-034 The first start after reset release SHALL behave as in REQ-018.

Structure
REQ-035 Package cmp3_pkg SHALL hold the state enum, VEC_COUNT=64, LAST_IDX=63 and the err_count width constant.
REQ-036 One sub-module, cmp3_golden (combinational: a,b -> exp_gt, exp_eq, exp_lt), SHALL provide the expected result.
REQ-037 The target RTL size SHALL be about 150-250 lines including the sub-module.

Verification
REQ-038 Correct comparator model, SETTLE_CYCLES=2, start pulse -> done after 192 cycles, err_count=0, pass=1, first_fail_valid=0.
REQ-039 DUT with dut_eq stuck at 0 -> err_count=8, first_fail_idx=0, pass=0.
REQ-040 DUT with gt and lt swapped -> err_count=56, first_fail_idx=1 (a=0,b=1).
REQ-041 DUT driving all outputs 1 -> err_count=64 (saturated maximum), first_fail_idx=0.
REQ-042 Second start pulse at idx=10 -> ignored; the sweep completes at the normal cycle count.
REQ-043 Assert rst at idx=20 -> all outputs 0 immediately; a new start gives the same results as REQ-038.
